// File: rtl/dma_apb_pkg.sv
// Shared types for the DMA stream-side APB master.
package dma_apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/dma_apb_stream_master_if.sv
// APB bus bundle between the DMA stream master and its slave.
interface dma_apb_stream_master_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic                  pslverr;
  logic [DATA_WIDTH-1:0] prdata;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/dma_rr_arbiter.sv
// Round-robin picker: the first requester strictly after i_ptr wins,
// wrapping from NUM_CH-1 back to 0.
module dma_rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_ptr,
  output logic [NUM_CH-1:0] o_grant_oh,
  output logic [CH_W-1:0]   o_grant_idx,
  output logic              o_any
);

  logic [CH_W-1:0] w_cand;

  // Scan from the farthest candidate to the nearest so the nearest hit overwrites.
  always_comb begin
    w_cand      = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    for (int off = NUM_CH; off >= 1; off--) begin
      w_cand = CH_W'((int'(i_ptr) + off) % NUM_CH);
      if (i_req[w_cand]) begin
        o_grant_idx = w_cand;
        o_any       = 1'b1;
      end
    end
  end

  assign o_grant_oh = o_any ? (NUM_CH'(1) << o_grant_idx) : '0;

endmodule

// File: rtl/dma_apb_stream_master.sv
// N-channel round-robin APB master for the DMA stream side.
// Optional ACCESS-phase watchdog: define DMA_APB_TIMEOUT_EN.
//
// state      | meaning
// APB_IDLE   | bus idle; arbitrate, ack requests that arrive already aborted
// APB_SETUP  | psel=1, penable=0 for one cycle
// APB_ACCESS | psel=1, penable=1; wait for pready (or watchdog expiry)
module dma_apb_stream_master
  import dma_apb_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                 aclk,
  input  logic                                 anreset,
  input  logic                                 aenable,
  input  logic [NUM_CH-1:0]                    i_req,
  input  logic [NUM_CH-1:0]                    i_write,
  input  logic [NUM_CH-1:0]                    i_abort,
  input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    i_addr,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    i_wdata,
  output logic [NUM_CH-1:0]                    o_done,
  output logic [NUM_CH-1:0]                    o_err,
  output logic [NUM_CH-1:0]                    o_abort_ack,
  output logic [DATA_WIDTH-1:0]                o_rdata,
  output logic                                 o_busy,
  dma_apb_stream_master_if.master              apb
);

  localparam int CH_W = $clog2(NUM_CH);

  if (NUM_CH < 2) begin : g_bad_num_ch
    $error("dma_apb_stream_master: NUM_CH must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("dma_apb_stream_master: TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_e            r_state;
  logic [CH_W-1:0]       r_ptr;
  logic [CH_W-1:0]       r_gnt;
  logic [NUM_CH-1:0]     r_gnt_oh;
  logic                  r_abort;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [NUM_CH-1:0]     r_done;
  logic [NUM_CH-1:0]     r_err;
  logic [NUM_CH-1:0]     r_abort_ack;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [NUM_CH-1:0]     w_pulsed;
  logic [NUM_CH-1:0]     w_cand_req;
  logic [NUM_CH-1:0]     w_idle_abort;
  logic [NUM_CH-1:0]     w_grant_oh;
  logic [CH_W-1:0]       w_grant_idx;
  logic                  w_grant_any;
  logic                  w_abort_now;
  logic                  w_expire;
  logic                  w_finish;
  logic                  w_fin_err;

  // A channel whose pulse is out this cycle still shows i_req; mask it so it
  // is neither granted nor acked a second time.
  assign w_pulsed     = r_done | r_abort_ack;
  assign w_cand_req   = i_req & ~i_abort & ~w_pulsed;
  assign w_idle_abort = i_req & i_abort & ~w_pulsed;
  assign w_abort_now  = r_abort | i_abort[r_gnt];

  dma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .i_req       (w_cand_req),
    .i_ptr       (r_ptr),
    .o_grant_oh  (w_grant_oh),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_grant_any)
  );

`ifdef DMA_APB_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCNT_W-1:0] r_tcnt;

  // ACCESS watchdog: reloaded in SETUP, counts down each stalled ACCESS cycle.
  always_ff @(posedge aclk or negedge anreset) begin
    if (!anreset) begin
      r_tcnt <= '0;
    end else if (r_state == APB_SETUP) begin
      r_tcnt <= TCNT_W'(TIMEOUT_CYCLES - 1);
    end else if (r_state == APB_ACCESS && !apb.pready && r_tcnt != '0) begin
      r_tcnt <= r_tcnt - 1'b1;
    end
  end

  assign w_expire = (r_state == APB_ACCESS) && !apb.pready && (r_tcnt == '0);
`else
  assign w_expire = 1'b0;
`endif

  // pready wins over a coincident expiry; expiry alone reports an error.
  assign w_finish  = (r_state == APB_ACCESS) && (apb.pready || w_expire);
  assign w_fin_err = apb.pready ? apb.pslverr : 1'b1;

  // Transfer sequencer with registered bus and pulse outputs.
  always_ff @(posedge aclk or negedge anreset) begin
    if (!anreset) begin
      r_state     <= APB_IDLE;
      r_ptr       <= CH_W'(NUM_CH - 1);
      r_gnt       <= '0;
      r_gnt_oh    <= '0;
      r_abort     <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_abort_ack <= '0;
      r_rdata     <= '0;
    end else begin
      r_done      <= '0;
      r_err       <= '0;
      r_abort_ack <= '0;
      case (r_state)
        APB_IDLE: begin
          r_abort_ack <= w_idle_abort;
          if (aenable && w_grant_any) begin
            r_gnt    <= w_grant_idx;
            r_gnt_oh <= w_grant_oh;
            r_ptr    <= w_grant_idx;
            r_paddr  <= i_addr[w_grant_idx];
            r_pwdata <= i_wdata[w_grant_idx];
            r_pwrite <= i_write[w_grant_idx];
            r_psel   <= 1'b1;
            r_abort  <= 1'b0;
            r_state  <= APB_SETUP;
          end
        end
        APB_SETUP: begin
          r_penable <= 1'b1;
          r_abort   <= w_abort_now;
          r_state   <= APB_ACCESS;
        end
        APB_ACCESS: begin
          if (w_finish) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_abort   <= 1'b0;
            r_state   <= APB_IDLE;
            if (w_abort_now) begin
              r_abort_ack <= r_gnt_oh;
            end else begin
              r_done <= r_gnt_oh;
              r_err  <= w_fin_err ? r_gnt_oh : '0;
              if (apb.pready && !r_pwrite) begin
                r_rdata <= apb.prdata;
              end
            end
          end else begin
            r_abort <= w_abort_now;
          end
        end
        default: r_state <= APB_IDLE;
      endcase
    end
  end

  assign apb.psel    = r_psel;
  assign apb.penable = r_penable;
  assign apb.pwrite  = r_pwrite;
  assign apb.paddr   = r_paddr;
  assign apb.pwdata  = r_pwdata;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_abort_ack = r_abort_ack;
  assign o_rdata     = r_rdata;
  assign o_busy      = (r_state != APB_IDLE);

endmodule

// File: tb/tb_dma_apb_stream_master.sv
// Scoreboard bench for dma_apb_stream_master.
// Slave model: paddr[11:8] = wait states, paddr[15:12]==E -> pslverr, ==F -> never ready.
module tb_dma_apb_stream_master;
  localparam int NCH = 4;
  localparam int AW  = 16;
  localparam int DW  = 32;

  typedef struct {
    int          ch;
    logic [AW-1:0] addr;
    logic        wr;
    logic [DW-1:0] wdata;
    int          abort_dly;
  } req_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic        wr;
    logic [DW-1:0] wdata;
  } bus_t;

  typedef struct {
    int          ch;
    logic        is_abort;
    logic        err;
    logic        chk_rd;
    logic [DW-1:0] rdata;
  } cpl_t;

  logic                   aclk    = 1'b0;
  logic                   anreset = 1'b0;
  logic                   aenable = 1'b0;
  logic [NCH-1:0]         i_req   = '0;
  logic [NCH-1:0]         i_write = '0;
  logic [NCH-1:0]         i_abort = '0;
  logic [NCH-1:0][AW-1:0] i_addr  = '0;
  logic [NCH-1:0][DW-1:0] i_wdata = '0;
  logic [NCH-1:0]         o_done;
  logic [NCH-1:0]         o_err;
  logic [NCH-1:0]         o_abort_ack;
  logic [DW-1:0]          o_rdata;
  logic                   o_busy;

  dma_apb_stream_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  dma_apb_stream_master #(
    .NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .aclk(aclk), .anreset(anreset), .aenable(aenable),
    .i_req(i_req), .i_write(i_write), .i_abort(i_abort),
    .i_addr(i_addr), .i_wdata(i_wdata),
    .o_done(o_done), .o_err(o_err), .o_abort_ack(o_abort_ack),
    .o_rdata(o_rdata), .o_busy(o_busy),
    .apb(apb)
  );

  always #5 aclk = ~aclk;

  int   n_checks = 0;
  int   n_err    = 0;
  req_t reqq[$];
  bus_t busq[$];
  cpl_t cplq[$];
  logic [AW-1:0] cur_addr = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] slv_rdata(input logic [AW-1:0] a);
    if (a == 16'h0320) return 32'hDEAD_BEEF;
    return {16'hC0DE, a};
  endfunction

  // APB slave model
  initial begin
    int wcnt;
    wcnt = 0;
    apb.pready = 1'b0; apb.pslverr = 1'b0; apb.prdata = '0;
    forever begin
      @(negedge aclk);
      if (apb.psel && apb.penable) begin
        apb.prdata  = slv_rdata(apb.paddr);
        apb.pslverr = (apb.paddr[15:12] == 4'hE);
        apb.pready  = (apb.paddr[15:12] != 4'hF) && (wcnt == int'(apb.paddr[11:8]));
        wcnt++;
      end else begin
        apb.pready = 1'b0; apb.pslverr = 1'b0; wcnt = 0;
      end
    end
  end

  // Requester model: posts queued requests, holds until the pulse, drops one cycle later
  initial begin
    logic [NCH-1:0] active, drop;
    int age [NCH];
    int dly [NCH];
    active = '0; drop = '0;
    for (int c = 0; c < NCH; c++) begin age[c] = 0; dly[c] = -1; end
    forever begin
      @(posedge aclk); #1;
      if (!anreset) begin
        i_req = '0; i_abort = '0; active = '0; drop = '0;
        reqq.delete();
        continue;
      end
      for (int c = 0; c < NCH; c++) begin
        if (drop[c]) begin
          i_req[c] = 1'b0; i_abort[c] = 1'b0; drop[c] = 1'b0; active[c] = 1'b0;
        end else if (active[c]) begin
          if (o_done[c] || o_abort_ack[c]) drop[c] = 1'b1;
          age[c]++;
          if (dly[c] > 0 && age[c] == dly[c]) i_abort[c] = 1'b1;
        end else begin
          for (int k = 0; k < reqq.size(); k++) begin
            if (reqq[k].ch == c) begin
              i_req[c]   = 1'b1;
              i_write[c] = reqq[k].wr;
              i_addr[c]  = reqq[k].addr;
              i_wdata[c] = reqq[k].wdata;
              dly[c]     = reqq[k].abort_dly;
              i_abort[c] = (reqq[k].abort_dly == 0);
              age[c]     = 0;
              active[c]  = 1'b1;
              reqq.delete(k);
              break;
            end
          end
        end
      end
    end
  end

  // Monitor: compares bus SETUP phases and per-channel pulses against the queues
  initial begin
    bus_t b;
    cpl_t e;
    forever begin
      @(negedge aclk);
      if (anreset) begin
        if (apb.psel && !apb.penable) begin
          if (busq.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL bus_unexpected: setup at paddr %0h, none expected", apb.paddr);
          end else begin
            b = busq.pop_front();
            cur_addr = b.addr;
            chk("bus_paddr", apb.paddr, b.addr);
            chk("bus_pwrite", apb.pwrite, b.wr);
            if (b.wr) chk("bus_pwdata", apb.pwdata, b.wdata);
          end
        end
        if (apb.psel && apb.penable) chk("bus_hold_paddr", apb.paddr, cur_addr);
        for (int c = 0; c < NCH; c++) begin
          if (o_err[c] && !o_done[c]) begin
            n_checks++; n_err++;
            $display("FAIL err_without_done: ch %0d o_err=1 o_done=0 required o_done=1", c);
          end
          if (o_done[c] || o_abort_ack[c]) begin
            if (cplq.size() == 0) begin
              n_checks++; n_err++;
              $display("FAIL cpl_unexpected: ch %0d done=%0b ack=%0b, none expected",
                       c, o_done[c], o_abort_ack[c]);
            end else begin
              e = cplq.pop_front();
              chk("cpl_ch", c, e.ch);
              chk("cpl_abort_ack", o_abort_ack[c], e.is_abort);
              chk("cpl_done", o_done[c], !e.is_abort);
              if (!e.is_abort) chk("cpl_err", o_err[c], e.err);
              if (e.chk_rd) chk("cpl_rdata", o_rdata, e.rdata);
            end
          end
        end
      end
    end
  end

  task automatic post(input int ch, input logic [AW-1:0] a, input logic wr,
                      input logic [DW-1:0] wd, input int adly);
    req_t r;
    r.ch = ch; r.addr = a; r.wr = wr; r.wdata = wd; r.abort_dly = adly;
    reqq.push_back(r);
  endtask

  task automatic exp_bus(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd);
    bus_t b;
    b.addr = a; b.wr = wr; b.wdata = wd;
    busq.push_back(b);
  endtask

  task automatic exp_cpl(input int ch, input logic ab, input logic err,
                         input logic chk_rd, input logic [DW-1:0] rd);
    cpl_t e;
    e.ch = ch; e.is_abort = ab; e.err = err; e.chk_rd = chk_rd; e.rdata = rd;
    cplq.push_back(e);
  endtask

  task automatic wait_idle(input string nm);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (reqq.size() == 0 && i_req == '0 && !o_busy && cplq.size() == 0 && busq.size() == 0)
        break;
    end
    chk({nm, "_drained"}, (i < 300), 1'b1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_psel"}, apb.psel, 0);
    chk({nm, "_penable"}, apb.penable, 0);
    chk({nm, "_pwrite"}, apb.pwrite, 0);
    chk({nm, "_paddr"}, apb.paddr, 0);
    chk({nm, "_pwdata"}, apb.pwdata, 0);
    chk({nm, "_done"}, o_done, 0);
    chk({nm, "_err"}, o_err, 0);
    chk({nm, "_abort_ack"}, o_abort_ack, 0);
    chk({nm, "_rdata"}, o_rdata, 0);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    anreset = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge aclk);
    anreset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    aenable = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    chk_all_zero("por");
    @(negedge aclk);
    anreset = 1'b1;

    // 1: single write, pready immediately
    @(negedge aclk);
    post(0, 16'h0010, 1'b1, 32'hA5A5_0001, -1);
    exp_bus(16'h0010, 1'b1, 32'hA5A5_0001);
    exp_cpl(0, 1'b0, 1'b0, 1'b0, '0);
    @(posedge aclk); #2;
    chk("t1_req_posted", i_req[0], 1'b1);
    @(posedge aclk); #2;
    chk("t1_psel_at_1", apb.psel, 1'b1);
    chk("t1_penable_at_1", apb.penable, 1'b0);
    @(posedge aclk); #2;
    chk("t1_penable_at_2", apb.penable, 1'b1);
    @(posedge aclk); #2;
    chk("t1_done_at_3", o_done[0], 1'b1);
    wait_idle("t1");

    // 2: read with 3 wait states
    post(1, 16'h0320, 1'b0, '0, -1);
    exp_bus(16'h0320, 1'b0, '0);
    exp_cpl(1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    wait_idle("t2");

    // aenable low holds off new grants
    aenable = 1'b0;
    post(2, 16'h0044, 1'b1, 32'h1111_2222, -1);
    exp_bus(16'h0044, 1'b1, 32'h1111_2222);
    exp_cpl(2, 1'b0, 1'b0, 1'b0, '0);
    repeat (6) @(negedge aclk);
    chk("en_low_busy", o_busy, 1'b0);
    chk("en_low_req_pending", i_req[2], 1'b1);
    aenable = 1'b1;
    wait_idle("en");

    // 3: all four channels, two requests each, after reset (pointer back to NUM_CH-1)
    do_reset();
    @(negedge aclk);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NCH; c++) begin
        logic [AW-1:0] a;
        logic          wr;
        logic [DW-1:0] wd;
        a  = AW'(16'h0040 + c * 8 + k * 4);
        wr = (c % 2 == 0);
        wd = DW'(32'h3000_0000 + c * 16 + k);
        post(c, a, wr, wd, -1);
        exp_bus(a, wr, wd);
        exp_cpl(c, 1'b0, 1'b0, !wr, {16'hC0DE, a});
      end
    end
    wait_idle("t3");

    // 4: slave error on ch2, ch3 right behind it
    post(2, 16'hE030, 1'b1, 32'h4444_0002, -1);
    post(3, 16'h0034, 1'b0, '0, -1);
    exp_bus(16'hE030, 1'b1, 32'h4444_0002);
    exp_bus(16'h0034, 1'b0, '0);
    exp_cpl(2, 1'b0, 1'b1, 1'b0, '0);
    exp_cpl(3, 1'b0, 1'b0, 1'b1, 32'hC0DE_0034);
    wait_idle("t4");

    // 5a: abort ch3 during ACCESS; bus completes, ack instead of done, rdata untouched
    post(3, 16'h0538, 1'b0, '0, 3);
    exp_bus(16'h0538, 1'b0, '0);
    exp_cpl(3, 1'b1, 1'b0, 1'b0, '0);
    wait_idle("t5a");
    chk("t5a_rdata_held", o_rdata, 32'hC0DE_0034);

    // 5b: abort already high in IDLE -> ack next cycle, no bus cycle
    post(1, 16'h0024, 1'b0, '0, 0);
    exp_cpl(1, 1'b1, 1'b0, 1'b0, '0);
    @(posedge aclk); #2;
    @(posedge aclk); #2;
    chk("t5b_ack_next", o_abort_ack[1], 1'b1);
    chk("t5b_no_psel", apb.psel, 1'b0);
    wait_idle("t5b");

`ifdef DMA_APB_TIMEOUT_EN
    // 6: stuck slave -> watchdog completion with error after 8 ACCESS cycles
    post(0, 16'hF000, 1'b0, '0, -1);
    exp_bus(16'hF000, 1'b0, '0);
    exp_cpl(0, 1'b0, 1'b1, 1'b0, '0);
    wait_idle("t6_timeout");
    chk("t6_rdata_held", o_rdata, 32'hC0DE_0034);
`endif

    // 6: reset in the middle of ACCESS clears everything, no pulse afterwards
    post(0, 16'hF004, 1'b0, '0, -1);
    exp_bus(16'hF004, 1'b0, '0);
    for (i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (apb.penable) break;
    end
    chk("t6_reached_access", (i < 20), 1'b1);
    repeat (2) @(negedge aclk);
    anreset = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge aclk);
    anreset = 1'b1;
    repeat (10) @(negedge aclk);
    chk("t6_idle_after", o_busy, 1'b0);
    chk("t6_busq_empty", busq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
